// File: rtl/regdump_pkg.sv
// -----------------------------------------------------------------------------
// regdump_pkg
// Shared types and constants for the register-file-to-SRAM dump controller.
//   REG_ADDR_W      : width of the register-file read address (8 registers max)
//   DEF_*_CYC       : default SRAM write phase lengths, in clock cycles
//   dump_state_t    : controller state encoding (also exported for debug)
//   max3            : helper used to size the shared phase timer
// -----------------------------------------------------------------------------
package regdump_pkg;

  localparam int REG_ADDR_W    = 3;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } dump_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_timer.sv
// -----------------------------------------------------------------------------
// dump_phase_timer
// Loadable down-counter that measures the SETUP / STROBE / HOLD phases.
// Loading value N makes zero_o rise N cycles later, so a phase lasting
// L cycles is started by loading L-1 on the edge that enters it.
//   clk, rst    : clock, asynchronous active-high reset
//   load_i      : load load_val_i on the next rising edge
//   load_val_i  : reload value
//   zero_o      : counter is at zero (current phase ends this cycle)
// -----------------------------------------------------------------------------
module dump_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
// Copies registers 0..NUM_REGS-1 of a combinational-read register file into an
// async SRAM at base_addr+index, using a setup / WE-strobe / hold write cycle.
//
// Control handshake: start is a level sampled only in IDLE; when seen there
// the dump is accepted, busy rises on the next edge and stays high until the
// controller is back in IDLE. Exactly one of done / aborted pulses for one
// cycle per accepted dump (done in the DONE state, aborted on the IDLE entry
// that an abort causes). start while busy is dropped, never queued.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, abort    : begin dump / stop dump early
//   base_addr       : SRAM address of word 0, captured on start
//   busy/done/aborted : status, see handshake above
//   rf_raddr/rf_rdata : register-file read port
//   mem_addr/mem_wdata/mem_drive/mem_we_n/mem_oe_n : SRAM interface
//   state_dbg       : current controller state
// -----------------------------------------------------------------------------
module regfile_dump_ctrl
  import regdump_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]     rf_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_drive,
  output logic                  mem_we_n,
  output logic                  mem_oe_n,
  output dump_state_t           state_dbg
);

  localparam int TW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  dump_state_t           state_q, state_d;
  logic [REG_ADDR_W-1:0] index_q, index_d;
  logic [REG_ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  drive_q, drive_d;
  logic                  we_n_q, we_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  abort_lat_q, abort_lat_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  dump_phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Every output register is computed from the next state, so mem_we_n_q is
  // low exactly while state_q is STROBE and never glitches.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    raddr_d     = raddr_q;
    base_d      = base_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    drive_d     = drive_q;
    we_n_d      = 1'b1;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    abort_lat_d = abort_lat_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      S_IDLE: begin
        abort_lat_d = 1'b0;
        if (start) begin
          base_d  = base_addr;
          index_d = '0;
          raddr_d = '0;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end

      S_READ: begin
        if (abort) begin
          drive_d   = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wdata_d  = rf_rdata;
          addr_d   = base_q + ADDR_W'(index_q);  // wraps modulo 2^ADDR_W
          drive_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TW'(SETUP_CYC - 1);
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        if (abort) begin
          // No WE pulse has been issued for this word, so it is dropped.
          drive_d   = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (tmr_zero) begin
          we_n_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYC - 1);
          state_d  = S_STROBE;
        end
      end

      S_STROBE: begin
        // Once WE is low the word is committed; abort only takes effect
        // after the hold phase.
        if (abort) abort_lat_d = 1'b1;
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD_CYC - 1);
          state_d  = S_HOLD;
        end else begin
          we_n_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (abort) abort_lat_d = 1'b1;
        if (tmr_zero) begin
          if (abort || abort_lat_q) begin
            drive_d     = 1'b0;
            busy_d      = 1'b0;
            aborted_d   = 1'b1;
            abort_lat_d = 1'b0;
            state_d     = S_IDLE;
          end else if (index_q == LAST_IDX) begin
            drive_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            index_d = index_q + 1'b1;
            raddr_d = index_q + 1'b1;
            state_d = S_READ;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        drive_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      raddr_q     <= '0;
      base_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      abort_lat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      raddr_q     <= raddr_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      drive_q     <= drive_d;
      we_n_q      <= we_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      abort_lat_q <= abort_lat_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign rf_raddr  = raddr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_drive = drive_q;
  assign mem_we_n  = we_n_q;
  assign mem_oe_n  = 1'b1;  // this block never reads the SRAM
  assign state_dbg = state_q;

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
Sequencer that copies the contents of the 3-bit-addressed, 16-bit register file to the external 12-bit-address / 16-bit-data async SRAM.
- Drives one register-file read port, then writes each word to SRAM at base_addr+index using timed setup / WE-strobe / hold phases.
- Replaces the free-running "write a register each slow tick" demo with a start/busy/done controlled, abortable dump.

Parameters:
NUM_REGS, 8, number of registers dumped (indices 0..NUM_REGS-1); 1..8
DATA_W, 16, register/SRAM data width
ADDR_W, 12, SRAM address width
SETUP_CYC, 1, cycles address/data are stable before WE falls; >=1
PULSE_CYC, 2, cycles mem_we_n held low; >=1
HOLD_CYC, 1, cycles address/data held after WE rises; >=1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin dump; sampled in IDLE only
abort  in  1  stop dump early
base_addr  in  ADDR_W  SRAM address of word 0; snapshotted on start
busy  out  1  high from accepted start until return to IDLE
done  out  1  1-cycle pulse after last word's HOLD completes
aborted  out  1  1-cycle pulse when an abort ends the dump
rf_raddr  out  3  register-file read address
rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_drive  out  1  tristate enable for SRAM data bus
mem_we_n  out  1  SRAM write enable, active-low
mem_oe_n  out  1  SRAM output enable, active-low; held 1 (reads never issued)

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is asynchronous, active-high.
- Reset values: busy=0, done=0, aborted=0, mem_we_n=1, mem_oe_n=1, mem_drive=0, mem_addr=0, mem_wdata=0, rf_raddr=0; state=IDLE, index=0. Reset mid-strobe forces mem_we_n=1 immediately (async).
- All outputs are registered.
- States: IDLE, READ, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - start=1 -> snapshot base_addr, index=0, rf_raddr=0, busy=1, go READ.
  - start=0 -> stay. abort is ignored in IDLE.
- READ (1 cycle): capture rf_rdata into mem_wdata; mem_addr=base+index (mod 2^ADDR_W, wraps silently); mem_drive=1; go SETUP.
- SETUP (SETUP_CYC cycles): mem_we_n=1; then go STROBE.
- STROBE (PULSE_CYC cycles): mem_we_n=0; then go HOLD.
- HOLD (HOLD_CYC cycles): mem_we_n=1, addr/data/drive still held. At end:
  - index==NUM_REGS-1 -> mem_drive=0, go DONE.
  - otherwise -> index+1, rf_raddr=index+1, go READ.
- DONE (1 cycle): done=1; busy falls when entering IDLE.
- Per-word cost: 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (defaults: 5). Full defaults dump: 40 cycles READ..HOLD, then 1 DONE cycle.
- Phase timer: down-counter sized to max of the three phase parameters, reloaded on each phase entry.
- Abort:
  - In READ or SETUP -> mem_drive=0, go IDLE, aborted=1 for one cycle; no WE pulse issued for the current word.
  - In STROBE or HOLD -> latch abort; the current word completes its full pulse and hold, then IDLE with aborted=1, done=0.
  - In DONE -> ignored; done still pulses.
- start while busy: ignored, never queued.
- start and abort together in IDLE: start wins, abort ignored.
- mem_we_n never glitches low outside STROBE. mem_addr and mem_wdata never change while mem_we_n=0 or during HOLD.

Decomposition:
- Package regdump_pkg:
  - state enum dump_state_t (IDLE..DONE)
  - default timing constants (SETUP/PULSE/HOLD)
  - REG_ADDR_W=3
- Sub-module dump_phase_timer: loadable down-counter with a zero flag, instantiated once for the phase timing.

Test Plan:
- Reset, then start with base_addr=0x100 and regs 0..7 preloaded 0xA000+i -> eight WE pulses of 2 cycles each; words 0xA000..0xA007 land at 0x100..0x107; done pulses at cycle 41; busy deasserts the next cycle.
- base_addr=0xFFE, NUM_REGS=4 -> writes to 0xFFE, 0xFFF, 0x000, 0x001 (wrap).
- abort during SETUP of word 3 -> exactly 3 WE pulses; aborted=1 one cycle; done never asserts; mem_drive=0 in IDLE.
- abort during STROBE of word 3 -> word 3 still gets a full 2-cycle pulse plus hold; total 4 writes, then aborted.
- start held high throughout a dump -> exactly one dump runs; a new dump begins only from IDLE after done.
- rst asserted while mem_we_n=0 -> mem_we_n=1 and busy=0 without waiting for a clock edge; next start dumps from index 0.
